// File: rtl/fp_norm_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fp_norm_seq
//  Purpose  : Sequential post-adder normalizer for single-precision add/sub.
//             Takes the 25-bit two's-complement mantissa sum and provisional
//             biased exponent, recovers sign/magnitude, then normalizes one
//             bit position per cycle.
//             The result is presented as sign/exponent/fraction behind a
//             valid/ready handshake.
//  Ports    : clk, rst (sync, active-high)
//             in_valid/in_ready, sum_in[24:0], exp_in[7:0]  - input side
//             out_valid/out_ready, sign_out, exp_out[7:0],
//             frac_out[22:0], zero_out, ovf_out, udf_out    - result side
//  Options  : FP_NORM_ROUND_EN - round-half-to-even on right shifts
//             (default: truncate)
//  Revision : 1.0 - initial release
// ============================================================================
module fp_norm_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [24:0] sum_in,
    input  logic [7:0]  exp_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sign_out,
    output logic [7:0]  exp_out,
    output logic [22:0] frac_out,
    output logic        zero_out,
    output logic        ovf_out,
    output logic        udf_out
);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_NORM = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    logic [1:0]  r_state_q,  w_state_d;
    logic        r_ready_q,  w_ready_d;
    logic        r_sign_q,   w_sign_d;
    logic [24:0] r_mag_q,    w_mag_d;
    logic [7:0]  r_exp_q,    w_exp_d;
    logic        r_oval_q,   w_oval_d;
    logic        r_osign_q,  w_osign_d;
    logic [7:0]  r_oexp_q,   w_oexp_d;
    logic [22:0] r_ofrac_q,  w_ofrac_d;
    logic        r_ozero_q,  w_ozero_d;
    logic        r_oovf_q,   w_oovf_d;
    logic        r_oudf_q,   w_oudf_d;

    // Magnitude after a one-position right shift.
    logic [24:0] w_mag_rsh;
`ifdef FP_NORM_ROUND_EN
    // Round half to even: bump when dropped bit and new LSB are both set.
    // A carry into bit 24 is picked up by a further right-shift cycle.
    assign w_mag_rsh = {1'b0, r_mag_q[24:1]} + {24'd0, r_mag_q[0] & r_mag_q[1]};
`else
    assign w_mag_rsh = {1'b0, r_mag_q[24:1]};
`endif

    always_comb begin
        w_state_d = r_state_q;
        w_sign_d  = r_sign_q;
        w_mag_d   = r_mag_q;
        w_exp_d   = r_exp_q;
        w_oval_d  = r_oval_q;
        w_osign_d = r_osign_q;
        w_oexp_d  = r_oexp_q;
        w_ofrac_d = r_ofrac_q;
        w_ozero_d = r_ozero_q;
        w_oovf_d  = r_oovf_q;
        w_oudf_d  = r_oudf_q;

        case (r_state_q)
            C_ST_IDLE: begin
                if (in_valid && r_ready_q) begin
                    w_sign_d  = sum_in[24];
                    // -2^24 wraps to itself, leaving bit 24 set for a right shift.
                    w_mag_d   = sum_in[24] ? (~sum_in + 25'd1) : sum_in;
                    w_exp_d   = exp_in;
                    w_state_d = C_ST_NORM;
                end
            end

            C_ST_NORM: begin
                if (r_exp_q == 8'hFF) begin
                    // Special operand: pass the fraction through untouched.
                    w_state_d = C_ST_DONE;
                    w_oval_d  = 1'b1;
                    w_osign_d = r_sign_q;
                    w_oexp_d  = 8'hFF;
                    w_ofrac_d = r_mag_q[22:0];
                    w_ozero_d = 1'b0;
                    w_oovf_d  = 1'b0;
                    w_oudf_d  = 1'b0;
                end else if (r_mag_q == 25'd0) begin
                    w_state_d = C_ST_DONE;
                    w_oval_d  = 1'b1;
                    w_osign_d = 1'b0;
                    w_oexp_d  = 8'd0;
                    w_ofrac_d = 23'd0;
                    w_ozero_d = 1'b1;
                    w_oovf_d  = 1'b0;
                    w_oudf_d  = 1'b0;
                end else if (r_mag_q[24]) begin
                    w_mag_d = w_mag_rsh;
                    w_exp_d = r_exp_q + 8'd1;
                    if (r_exp_q == 8'hFE) begin
                        // Incremented exponent hits 255: infinity.
                        w_state_d = C_ST_DONE;
                        w_oval_d  = 1'b1;
                        w_osign_d = r_sign_q;
                        w_oexp_d  = 8'hFF;
                        w_ofrac_d = 23'd0;
                        w_ozero_d = 1'b0;
                        w_oovf_d  = 1'b1;
                        w_oudf_d  = 1'b0;
                    end
                end else if (r_mag_q[23]) begin
                    w_state_d = C_ST_DONE;
                    w_oval_d  = 1'b1;
                    w_osign_d = r_sign_q;
                    w_oexp_d  = r_exp_q;
                    w_ofrac_d = r_mag_q[22:0];
                    w_ozero_d = 1'b0;
                    w_oovf_d  = 1'b0;
                    w_oudf_d  = 1'b0;
                end else if (r_exp_q <= 8'd1) begin
                    // No exponent range left to shift into: denormal.
                    w_state_d = C_ST_DONE;
                    w_oval_d  = 1'b1;
                    w_osign_d = r_sign_q;
                    w_oexp_d  = 8'd0;
                    w_ofrac_d = r_mag_q[22:0];
                    w_ozero_d = 1'b0;
                    w_oovf_d  = 1'b0;
                    w_oudf_d  = 1'b1;
                end else begin
                    w_mag_d = {r_mag_q[23:0], 1'b0};
                    w_exp_d = r_exp_q - 8'd1;
                end
            end

            C_ST_DONE: begin
                if (out_ready) begin
                    w_oval_d  = 1'b0;
                    w_state_d = C_ST_IDLE;
                end
            end

            default: begin
                w_state_d = C_ST_IDLE;
            end
        endcase

        // Registered decode of the next state keeps in_ready low during reset.
        w_ready_d = (w_state_d == C_ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= C_ST_IDLE;
            r_ready_q <= 1'b0;
            r_sign_q  <= 1'b0;
            r_mag_q   <= 25'd0;
            r_exp_q   <= 8'd0;
            r_oval_q  <= 1'b0;
            r_osign_q <= 1'b0;
            r_oexp_q  <= 8'd0;
            r_ofrac_q <= 23'd0;
            r_ozero_q <= 1'b0;
            r_oovf_q  <= 1'b0;
            r_oudf_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_ready_q <= w_ready_d;
            r_sign_q  <= w_sign_d;
            r_mag_q   <= w_mag_d;
            r_exp_q   <= w_exp_d;
            r_oval_q  <= w_oval_d;
            r_osign_q <= w_osign_d;
            r_oexp_q  <= w_oexp_d;
            r_ofrac_q <= w_ofrac_d;
            r_ozero_q <= w_ozero_d;
            r_oovf_q  <= w_oovf_d;
            r_oudf_q  <= w_oudf_d;
        end
    end

    assign in_ready  = r_ready_q;
    assign out_valid = r_oval_q;
    assign sign_out  = r_osign_q;
    assign exp_out   = r_oexp_q;
    assign frac_out  = r_ofrac_q;
    assign zero_out  = r_ozero_q;
    assign ovf_out   = r_oovf_q;
    assign udf_out   = r_oudf_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_norm_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_norm_seq
//  Purpose  : Self-checking bench for fp_norm_seq: directed vector table,
//             reset/abort sequence and randomized vectors against a
//             leading-one based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp_norm_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [24:0] sum_in = '0;
    logic [7:0]  exp_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        sign_out;
    logic [7:0]  exp_out;
    logic [22:0] frac_out;
    logic        zero_out;
    logic        ovf_out;
    logic        udf_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp_norm_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .exp_in    (exp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign_out  (sign_out),
        .exp_out   (exp_out),
        .frac_out  (frac_out),
        .zero_out  (zero_out),
        .ovf_out   (ovf_out),
        .udf_out   (udf_out)
    );

    typedef struct {
        logic [24:0] sum;
        logic [7:0]  ex;
        logic        sign;
        logic [7:0]  eexp;
        logic [22:0] frac;
        logic        z;
        logic        o;
        logic        u;
        int          lat;
        int          stall;
    } vec_t;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: derive result from the leading-one position directly.
    function automatic vec_t model(input logic [24:0] s, input logic [7:0] e);
        vec_t r;
        int   m, mm, ex, p, sh, a;
        r.sum = s; r.ex = e; r.stall = 0;
        r.sign = s[24]; r.eexp = 0; r.frac = 0; r.z = 0; r.o = 0; r.u = 0; r.lat = 1;
        m = s[24] ? ((33554432 - int'(s)) % 33554432) : int'(s);
        if (e == 8'd255) begin
            r.eexp = 255; r.frac = 23'(m % 8388608);
        end else if (m == 0) begin
            r.sign = 0; r.z = 1;
        end else if (m >= 16777216) begin
            mm = m / 2;
`ifdef FP_NORM_ROUND_EN
            if ((m % 2 == 1) && (mm % 2 == 1)) mm = mm + 1;
`endif
            ex = int'(e) + 1;
            if (ex == 255) begin
                r.eexp = 255; r.o = 1; r.lat = 1;
            end else if (mm >= 16777216) begin
                ex = ex + 1; mm = mm / 2;
                if (ex == 255) begin
                    r.eexp = 255; r.o = 1; r.lat = 2;
                end else begin
                    r.eexp = 8'(ex); r.frac = 23'(mm % 8388608); r.lat = 3;
                end
            end else begin
                r.eexp = 8'(ex); r.frac = 23'(mm % 8388608); r.lat = 2;
            end
        end else begin
            p = 0;
            for (int b = 0; b < 24; b++) if (((m >> b) & 1) == 1) p = b;
            sh = 23 - p;
            a  = (e > 1) ? int'(e) - 1 : 0;
            if (sh <= a) begin
                r.eexp = 8'(int'(e) - sh); r.frac = 23'((m << sh) % 8388608); r.lat = sh + 1;
            end else begin
                r.eexp = 0; r.frac = 23'((m << a) % 8388608); r.u = 1; r.lat = a + 1;
            end
        end
        return r;
    endfunction

    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, " sign"}, int'(sign_out), int'(v.sign));
        chk({tag, " exp"},  int'(exp_out),  int'(v.eexp));
        chk({tag, " frac"}, int'(frac_out), int'(v.frac));
        chk({tag, " zero"}, int'(zero_out), int'(v.z));
        chk({tag, " ovf"},  int'(ovf_out),  int'(v.o));
        chk({tag, " udf"},  int'(udf_out),  int'(v.u));
    endtask

    task automatic run_vec(input string tag, input vec_t v, input bit full);
        int n;
        bit ok;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) begin chk({tag, " ready timeout"}, 0, 1); return; end
        in_valid = 1'b1; sum_in = v.sum; exp_in = v.ex;
        @(posedge clk); #1;
        in_valid = 1'b0; sum_in = $urandom; exp_in = 8'($urandom);
        n = 0; ok = 0;
        while (n < 40) begin
            @(posedge clk); #1; n++;
            if (out_valid) begin ok = 1; break; end
        end
        if (!ok) begin chk({tag, " valid timeout"}, 0, 1); return; end
        if (full) chk({tag, " latency"}, n, v.lat);
        else if (n != v.lat) chk({tag, " latency"}, n, v.lat);
        if (full) check_outs(tag, v);
        else begin
            if (sign_out != v.sign || exp_out != v.eexp || frac_out != v.frac ||
                zero_out != v.z || ovf_out != v.o || udf_out != v.u)
                check_outs(tag, v);
            else total++;
        end
        for (int i = 0; i < v.stall; i++) begin
            @(posedge clk); #1;
            chk({tag, " hold valid"}, int'(out_valid), 1);
            chk({tag, " hold in_ready"}, int'(in_ready), 0);
            check_outs({tag, " hold"}, v);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        if (full) begin
            chk({tag, " valid drop"}, int'(out_valid), 0);
            chk({tag, " ready back"}, int'(in_ready), 1);
        end
    endtask

    vec_t tbl[12];
    vec_t rv;

    initial begin
        tbl[0]  = '{25'h0800000, 8'd127, 1'b0, 8'd127, 23'h0,      1'b0, 1'b0, 1'b0, 1,  0};
        tbl[1]  = '{25'h1800000, 8'd127, 1'b1, 8'd127, 23'h0,      1'b0, 1'b0, 1'b0, 1,  0};
        tbl[2]  = '{25'h1000000, 8'd127, 1'b1, 8'd128, 23'h0,      1'b0, 1'b0, 1'b0, 2,  0};
        tbl[3]  = '{25'h0000001, 8'd127, 1'b0, 8'd104, 23'h0,      1'b0, 1'b0, 1'b0, 24, 5};
        tbl[4]  = '{25'h0000100, 8'd3,   1'b0, 8'd0,   23'h000400, 1'b0, 1'b0, 1'b1, 3,  0};
        tbl[5]  = '{25'h0000000, 8'd127, 1'b0, 8'd0,   23'h0,      1'b1, 1'b0, 1'b0, 1,  0};
        tbl[6]  = '{25'h1000000, 8'd254, 1'b1, 8'd255, 23'h0,      1'b0, 1'b1, 1'b0, 1,  0};
        tbl[7]  = '{25'h1FFFFFF, 8'd127, 1'b1, 8'd104, 23'h0,      1'b0, 1'b0, 1'b0, 24, 0};
        tbl[8]  = '{25'h0FFFFFF, 8'd10,  1'b0, 8'd10,  23'h7FFFFF, 1'b0, 1'b0, 1'b0, 1,  0};
        tbl[9]  = '{25'h0123456, 8'd255, 1'b0, 8'd255, 23'h123456, 1'b0, 1'b0, 1'b0, 1,  0};
        tbl[10] = '{25'h0000001, 8'd0,   1'b0, 8'd0,   23'h000001, 1'b0, 1'b0, 1'b1, 1,  0};
        tbl[11] = '{25'h0400001, 8'd50,  1'b0, 8'd49,  23'h000002, 1'b0, 1'b0, 1'b0, 2,  2};

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset in_ready", int'(in_ready), 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset fields", int'({sign_out, exp_out, frac_out, zero_out, ovf_out, udf_out}), 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("post-reset in_ready", int'(in_ready), 1);

        foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i], 1'b1);

        // Abort mid-normalization
        @(negedge clk);
        in_valid = 1'b1; sum_in = 25'h0000001; exp_in = 8'd127;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("abort out_valid", int'(out_valid), 0);
        chk("abort in_ready", int'(in_ready), 0);
        chk("abort fields", int'({sign_out, exp_out, frac_out, zero_out, ovf_out, udf_out}), 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("abort ready back", int'(in_ready), 1);
        begin
            int seen = 0;
            for (int i = 0; i < 30; i++) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            chk("abort no spurious valid", seen, 0);
        end

        // Randomized vectors against the model
        for (int i = 0; i < 300; i++) begin
            logic [24:0] s;
            logic [7:0]  e;
            s = 25'($urandom) >> $urandom_range(0, 24);
            if ($urandom_range(0, 1) == 1) s = 25'(-s);
            if ($urandom_range(0, 19) == 0) s = 25'h1000000;
            case ($urandom_range(0, 7))
                0: e = 8'd0;
                1: e = 8'd1;
                2: e = 8'($urandom_range(2, 6));
                3: e = 8'd254;
                4: e = 8'd255;
                default: e = 8'($urandom);
            endcase
            rv = model(s, e);
            rv.stall = $urandom_range(0, 2);
            run_vec($sformatf("rnd%0d s=%h e=%0d", i, s, e), rv, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
